// File: rtl/game_pkg.sv
// Shared encodings for the game-flow controller: screen states, stage tasks,
// menu sizes and small classification helpers.
package game_pkg;

    typedef enum logic [3:0] {
        S_TITLE    = 4'd0,
        S_STAFF    = 4'd1,
        S_STAGE1   = 4'd2,
        S_SUCCESS1 = 4'd3,
        S_STAGE2   = 4'd4,
        S_SUCCESS2 = 4'd5,
        S_STAGE3   = 4'd6,
        S_SUCCESS3 = 4'd7,
        S_FAIL     = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        T_NONE       = 2'd0,
        T_FIND_KEY   = 2'd1,
        T_FIND_LIGHT = 2'd2,
        T_FIND_DOOR  = 2'd3
    } todo_e;

    localparam int TITLE_ITEMS   = 3;
    localparam int SUCCESS_ITEMS = 2;
    localparam int FAIL_ITEMS    = 2;
    localparam int SINGLE_ITEMS  = 1;

    localparam logic [1:0] LIFE_FULL   = 2'd3;
    localparam logic [1:0] KEYS_NEEDED = 2'd3;

    function automatic logic is_stage(state_e s);
        return (s == S_STAGE1) || (s == S_STAGE2) || (s == S_STAGE3);
    endfunction

    // Highest selectable cursor index on each screen.
    function automatic logic [1:0] cursor_max(state_e s);
        unique case (s)
            S_TITLE:                return 2'(TITLE_ITEMS - 1);
            S_SUCCESS1, S_SUCCESS2: return 2'(SUCCESS_ITEMS - 1);
            S_FAIL:                 return 2'(FAIL_ITEMS - 1);
            default:                return 2'(SINGLE_ITEMS - 1);
        endcase
    endfunction

endpackage

// File: rtl/menu_cursor.sv
// Saturating menu cursor: up/down step within [0, max], synchronous clear
// wins over movement, and simultaneous up+down cancel out.
module menu_cursor (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       up,
    input  logic       down,
    input  logic [1:0] max,
    output logic [1:0] cursor
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor <= 2'd0;
        end else if (clear) begin
            cursor <= 2'd0;
        end else if (up && !down && cursor != 2'd0) begin
            cursor <= cursor - 2'd1;
        end else if (down && !up && cursor < max) begin
            cursor <= cursor + 2'd1;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game-flow controller: screen FSM, per-stage task/key/life
// tracking, stage unlock mask and menu cursor, all outputs registered.
module game_flow_ctrl
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    input  logic       ev_key,
    input  logic       ev_light,
    input  logic       ev_door,
    input  logic       ev_hit,
    output logic [3:0] state,
    output logic [1:0] todo,
    output logic [1:0] key_find,
    output logic [1:0] life,
    output logic [3:0] play_valid,
    output logic [1:0] cursor,
    output logic       stage_start
);

    state_e     state_q, state_d;
    todo_e      todo_q, todo_d;
    logic [1:0] key_q, key_d;
    logic [1:0] life_q, life_d;
    logic [3:0] pv_q, pv_d;
    logic       start_q, start_d;
    logic       in_stage;
    logic       state_change;

    assign in_stage     = is_stage(state_q);
    assign state_change = (state_d != state_q);

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        todo_d  = todo_q;
        key_d   = key_q;
        life_d  = life_q;
        pv_d    = pv_q;
        start_d = 1'b0;

        if (in_stage) begin
            // Task decisions look at todo_q, so a key and the door in one
            // cycle cannot both count.
            if (ev_key && todo_q == T_FIND_KEY) begin
                key_d = key_q + 2'd1;
                if (key_q == KEYS_NEEDED - 2'd1) todo_d = T_FIND_DOOR;
            end
            if (ev_light && todo_q == T_FIND_LIGHT) todo_d = T_FIND_KEY;
            if (ev_door && todo_q == T_FIND_DOOR) begin
                unique case (state_q)
                    S_STAGE1: state_d = S_SUCCESS1;
                    S_STAGE2: state_d = S_SUCCESS2;
                    default:  state_d = S_SUCCESS3;
                endcase
            end
            // Applied last so a fatal hit overrides a same-cycle door.
            if (ev_hit && state_q == S_STAGE3 && life_q != 2'd0) begin
                life_d = life_q - 2'd1;
                if (life_q == 2'd1) state_d = S_FAIL;
            end
        end else if (btn_sel) begin
            unique case (state_q)
                S_TITLE: begin
                    if (pv_q[cursor + 2'd1]) begin
                        unique case (cursor)
                            2'd0:    state_d = S_STAGE1;
                            2'd1:    state_d = S_STAGE2;
                            default: state_d = S_STAGE3;
                        endcase
                    end
                end
                S_SUCCESS1: state_d = (cursor == 2'd0) ? S_STAGE2 : S_TITLE;
                S_SUCCESS2: state_d = (cursor == 2'd0) ? S_STAGE3 : S_TITLE;
                S_FAIL:     state_d = (cursor == 2'd0) ? S_STAGE3 : S_TITLE;
                S_SUCCESS3: state_d = S_STAFF;
                default:    state_d = S_TITLE;
            endcase
        end

        if (state_change && is_stage(state_d)) begin
            start_d = 1'b1;
            key_d   = 2'd0;
            life_d  = LIFE_FULL;
            todo_d  = (state_d == S_STAGE2) ? T_FIND_LIGHT : T_FIND_KEY;
        end else if (!is_stage(state_d)) begin
            todo_d = T_NONE;
        end

        if (state_d == S_SUCCESS1) pv_d[2] = 1'b1;
        if (state_d == S_SUCCESS2) pv_d[3] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_TITLE;
            todo_q  <= T_NONE;
            key_q   <= 2'd0;
            life_q  <= LIFE_FULL;
            pv_q    <= 4'b0010;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            todo_q  <= todo_d;
            key_q   <= key_d;
            life_q  <= life_d;
            pv_q    <= pv_d;
            start_q <= start_d;
        end
    end

    // Buttons do nothing inside a stage; any screen change homes the cursor.
    menu_cursor u_cursor (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_change),
        .up     (btn_up && !in_stage),
        .down   (btn_down && !in_stage),
        .max    (cursor_max(state_q)),
        .cursor (cursor)
    );

    assign state       = state_q;
    assign todo        = todo_q;
    assign key_find    = key_q;
    assign life        = life_q;
    assign play_valid  = pv_q;
    assign stage_start = start_q;

endmodule
